// File: rtl/reorder_buffer_if.sv
// Bundle of decoder, writeback, query and commit signals around the reorder buffer.
// The master side is the surrounding pipeline; the slave side is the buffer itself.
interface reorder_buffer_if #(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_CNT_WIDTH  = 5
) ();
    logic                      dec_valid;
    logic [1:0]                dec_kind;
    logic [REG_CNT_WIDTH-1:0]  dec_rd;

    logic                      alu_valid;
    logic [ROB_SIZE_WIDTH-1:0] alu_id;
    logic [XLEN-1:0]           alu_val;
    logic                      alu_mispredict;
    logic [XLEN-1:0]           alu_target;

    logic                      lsb_valid;
    logic [ROB_SIZE_WIDTH-1:0] lsb_id;
    logic [XLEN-1:0]           lsb_val;

    logic [ROB_SIZE_WIDTH-1:0] q_id1;
    logic [ROB_SIZE_WIDTH-1:0] q_id2;
    logic                      q_ready1;
    logic                      q_ready2;
    logic [XLEN-1:0]           q_val1;
    logic [XLEN-1:0]           q_val2;

    logic                      rob_full;
    logic [ROB_SIZE_WIDTH-1:0] rob_tail_id;
    logic [ROB_SIZE_WIDTH-1:0] rob_head_id;
    logic                      rob_ready;
    logic [REG_CNT_WIDTH-1:0]  rob_rd;
    logic [XLEN-1:0]           rob_val;
    logic                      rob_store_commit;
    logic                      rob_flush;
    logic [XLEN-1:0]           rob_jump_pc;
    logic                      rob_halt;

    modport master (
        output dec_valid, dec_kind, dec_rd,
        output alu_valid, alu_id, alu_val, alu_mispredict, alu_target,
        output lsb_valid, lsb_id, lsb_val,
        output q_id1, q_id2,
        input  q_ready1, q_ready2, q_val1, q_val2,
        input  rob_full, rob_tail_id, rob_head_id,
        input  rob_ready, rob_rd, rob_val, rob_store_commit,
        input  rob_flush, rob_jump_pc, rob_halt
    );

    modport slave (
        input  dec_valid, dec_kind, dec_rd,
        input  alu_valid, alu_id, alu_val, alu_mispredict, alu_target,
        input  lsb_valid, lsb_id, lsb_val,
        input  q_id1, q_id2,
        output q_ready1, q_ready2, q_val1, q_val2,
        output rob_full, rob_tail_id, rob_head_id,
        output rob_ready, rob_rd, rob_val, rob_store_commit,
        output rob_flush, rob_jump_pc, rob_halt
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ids, collects ALU/LSB results, retires one entry per cycle.
// Optional macro ROB_QUERY_BYPASS_EN forwards same-cycle writebacks to the operand query ports.
module reorder_buffer #(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int REG_CNT_WIDTH  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    reorder_buffer_if.slave  rob_bus
);
    localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0]   DEPTH_CNT = (ROB_SIZE_WIDTH + 1)'(DEPTH);
    localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE   = (ROB_SIZE_WIDTH + 1)'(1);
    localparam logic [ROB_SIZE_WIDTH-1:0] ID_ONE    = ROB_SIZE_WIDTH'(1);

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_HALT   = 2'd3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_t;

    logic [DEPTH-1:0]          busy_r;
    logic [DEPTH-1:0]          ready_r;
    logic [DEPTH-1:0]          mis_r;
    logic [1:0]                kind_r   [DEPTH];
    logic [REG_CNT_WIDTH-1:0]  rd_r     [DEPTH];
    logic [XLEN-1:0]           val_r    [DEPTH];
    logic [XLEN-1:0]           target_r [DEPTH];

    logic [ROB_SIZE_WIDTH-1:0] head_r;
    logic [ROB_SIZE_WIDTH-1:0] tail_r;
    logic [ROB_SIZE_WIDTH:0]   count_r;
    logic [ROB_SIZE_WIDTH:0]   count_nxt_s;

    halt_state_t               state_r;
    halt_state_t               state_nxt_s;

    logic                      full_s;
    logic                      alloc_s;
    logic                      commit_s;
    logic                      flush_s;
    logic [1:0]                head_kind_s;
    logic                      lsb_shadowed_s;

    logic                      rob_ready_r;
    logic [REG_CNT_WIDTH-1:0]  rob_rd_r;
    logic [XLEN-1:0]           rob_val_r;
    logic                      rob_store_commit_r;
    logic                      rob_flush_r;
    logic [XLEN-1:0]           rob_jump_pc_r;

    logic                      q_ready1_s;
    logic                      q_ready2_s;
    logic [XLEN-1:0]           q_val1_s;
    logic [XLEN-1:0]           q_val2_s;

    // Retire / allocate decisions for this cycle, all from pre-edge state.
    always_comb begin
        full_s         = (count_r == DEPTH_CNT);
        head_kind_s    = kind_r[head_r];
        commit_s       = busy_r[head_r] && ready_r[head_r] && (state_r == ST_RUN);
        flush_s        = commit_s && (head_kind_s == KIND_BRANCH) && mis_r[head_r];
        alloc_s        = rob_bus.dec_valid && !full_s;
        lsb_shadowed_s = rob_bus.alu_valid && (rob_bus.alu_id == rob_bus.lsb_id);
    end

    // Occupancy counter next value; a same-cycle commit does not make room for the allocation.
    always_comb begin
        count_nxt_s = count_r;
        case ({alloc_s, commit_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Halt FSM next state: once a HALT retires, retirement stops until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (commit_s && (head_kind_s == KIND_HALT)) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Head/tail pointers and occupancy; a mispredict flush rewinds everything to id 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (commit_s) begin
                head_r <= head_r + ID_ONE;
            end
            if (alloc_s) begin
                tail_r <= tail_r + ID_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage: retire clears head, allocate fills tail, writebacks mark results (ALU wins a tie).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r  <= '0;
            ready_r <= '0;
            mis_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kind_r[i]   <= KIND_REG;
                rd_r[i]     <= '0;
                val_r[i]    <= '0;
                target_r[i] <= '0;
            end
        end else if (flush_s) begin
            busy_r  <= '0;
            ready_r <= '0;
            mis_r   <= '0;
        end else begin
            if (commit_s) begin
                busy_r[head_r]  <= 1'b0;
                ready_r[head_r] <= 1'b0;
            end
            if (alloc_s) begin
                busy_r[tail_r]   <= 1'b1;
                ready_r[tail_r]  <= (rob_bus.dec_kind == KIND_STORE) ||
                                    (rob_bus.dec_kind == KIND_HALT);
                mis_r[tail_r]    <= 1'b0;
                kind_r[tail_r]   <= rob_bus.dec_kind;
                rd_r[tail_r]     <= rob_bus.dec_rd;
                val_r[tail_r]    <= '0;
                target_r[tail_r] <= '0;
            end
            if (rob_bus.alu_valid && busy_r[rob_bus.alu_id]) begin
                ready_r[rob_bus.alu_id]  <= 1'b1;
                val_r[rob_bus.alu_id]    <= rob_bus.alu_val;
                mis_r[rob_bus.alu_id]    <= rob_bus.alu_mispredict;
                target_r[rob_bus.alu_id] <= rob_bus.alu_target;
            end
            if (rob_bus.lsb_valid && busy_r[rob_bus.lsb_id] && !lsb_shadowed_s) begin
                ready_r[rob_bus.lsb_id] <= 1'b1;
                val_r[rob_bus.lsb_id]   <= rob_bus.lsb_val;
            end
        end
    end

    // Commit-side pulses, high for exactly the cycle after the retiring edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rob_ready_r        <= 1'b0;
            rob_rd_r           <= '0;
            rob_val_r          <= '0;
            rob_store_commit_r <= 1'b0;
            rob_flush_r        <= 1'b0;
            rob_jump_pc_r      <= '0;
        end else begin
            rob_ready_r        <= commit_s && (head_kind_s == KIND_REG);
            rob_rd_r           <= (commit_s && (head_kind_s == KIND_REG)) ? rd_r[head_r] : '0;
            rob_val_r          <= (commit_s && (head_kind_s == KIND_REG)) ? val_r[head_r] : '0;
            rob_store_commit_r <= commit_s && (head_kind_s == KIND_STORE);
            rob_flush_r        <= flush_s;
            rob_jump_pc_r      <= flush_s ? target_r[head_r] : '0;
        end
    end

    // Operand lookup; the bypass variant also forwards results arriving this cycle.
    always_comb begin
        q_ready1_s = busy_r[rob_bus.q_id1] && ready_r[rob_bus.q_id1];
        q_val1_s   = val_r[rob_bus.q_id1];
        q_ready2_s = busy_r[rob_bus.q_id2] && ready_r[rob_bus.q_id2];
        q_val2_s   = val_r[rob_bus.q_id2];
`ifdef ROB_QUERY_BYPASS_EN
        if (rob_bus.alu_valid && (rob_bus.alu_id == rob_bus.q_id1) && busy_r[rob_bus.q_id1]) begin
            q_ready1_s = 1'b1;
            q_val1_s   = rob_bus.alu_val;
        end else if (rob_bus.lsb_valid && (rob_bus.lsb_id == rob_bus.q_id1) && busy_r[rob_bus.q_id1]) begin
            q_ready1_s = 1'b1;
            q_val1_s   = rob_bus.lsb_val;
        end else begin
            q_val1_s   = val_r[rob_bus.q_id1];
        end
        if (rob_bus.alu_valid && (rob_bus.alu_id == rob_bus.q_id2) && busy_r[rob_bus.q_id2]) begin
            q_ready2_s = 1'b1;
            q_val2_s   = rob_bus.alu_val;
        end else if (rob_bus.lsb_valid && (rob_bus.lsb_id == rob_bus.q_id2) && busy_r[rob_bus.q_id2]) begin
            q_ready2_s = 1'b1;
            q_val2_s   = rob_bus.lsb_val;
        end else begin
            q_val2_s   = val_r[rob_bus.q_id2];
        end
`else
        if (rob_bus.alu_valid || rob_bus.lsb_valid) begin
            q_val1_s = val_r[rob_bus.q_id1];
        end else begin
            q_val1_s = val_r[rob_bus.q_id1];
        end
`endif
    end

    assign rob_bus.q_ready1         = q_ready1_s;
    assign rob_bus.q_ready2         = q_ready2_s;
    assign rob_bus.q_val1           = q_val1_s;
    assign rob_bus.q_val2           = q_val2_s;
    assign rob_bus.rob_full         = full_s;
    assign rob_bus.rob_tail_id      = tail_r;
    assign rob_bus.rob_head_id      = head_r;
    assign rob_bus.rob_ready        = rob_ready_r;
    assign rob_bus.rob_rd           = rob_rd_r;
    assign rob_bus.rob_val          = rob_val_r;
    assign rob_bus.rob_store_commit = rob_store_commit_r;
    assign rob_bus.rob_flush        = rob_flush_r;
    assign rob_bus.rob_jump_pc      = rob_jump_pc_r;
    assign rob_bus.rob_halt         = (state_r == ST_HALTED);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, wrap/full, in-order retire, flush, store/halt, query.
module tb_reorder_buffer;
    logic clk;
    logic rst_n;
    int   check_cnt;
    int   error_cnt;
    logic exp_byp_s;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rob_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid = 1'b0; bus.dec_kind = 2'd0; bus.dec_rd = 5'd0;
        bus.alu_valid = 1'b0; bus.alu_id = 3'd0; bus.alu_val = 32'd0;
        bus.alu_mispredict = 1'b0; bus.alu_target = 32'd0;
        bus.lsb_valid = 1'b0; bus.lsb_id = 3'd0; bus.lsb_val = 32'd0;
        bus.q_id1 = 3'd0; bus.q_id2 = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] kind, input logic [4:0] rd);
        bus.dec_valid = 1'b1; bus.dec_kind = kind; bus.dec_rd = rd;
        step();
        bus.dec_valid = 1'b0;
    endtask

    task automatic alu_wb(input logic [2:0] id, input logic [31:0] val, input logic mis, input logic [31:0] tgt);
        bus.alu_valid = 1'b1; bus.alu_id = id; bus.alu_val = val;
        bus.alu_mispredict = mis; bus.alu_target = tgt;
        step();
        bus.alu_valid = 1'b0; bus.alu_mispredict = 1'b0;
    endtask

    task automatic lsb_wb(input logic [2:0] id, input logic [31:0] val);
        bus.lsb_valid = 1'b1; bus.lsb_id = id; bus.lsb_val = val;
        step();
        bus.lsb_valid = 1'b0;
    endtask

    initial begin
        check_cnt = 0;
        error_cnt = 0;
`ifdef ROB_QUERY_BYPASS_EN
        exp_byp_s = 1'b1;
`else
        exp_byp_s = 1'b0;
`endif
        idle();
        rst_n = 1'b0;
        step();
        step();
        check_value("rst_full", {31'd0, bus.rob_full}, 32'd0);
        check_value("rst_head", {29'd0, bus.rob_head_id}, 32'd0);
        check_value("rst_tail", {29'd0, bus.rob_tail_id}, 32'd0);
        check_value("rst_ready", {31'd0, bus.rob_ready}, 32'd0);
        check_value("rst_flush", {31'd0, bus.rob_flush}, 32'd0);
        check_value("rst_halt", {31'd0, bus.rob_halt}, 32'd0);
        check_value("rst_store", {31'd0, bus.rob_store_commit}, 32'd0);
        rst_n = 1'b1;

        // basic allocate / writeback / commit
        alloc(2'd0, 5'd5);
        check_value("t1_tail", {29'd0, bus.rob_tail_id}, 32'd1);
        alu_wb(3'd0, 32'h1234, 1'b0, 32'd0);
        check_value("t1_ready_early", {31'd0, bus.rob_ready}, 32'd0);
        bus.q_id1 = 3'd0;
        #1;
        check_value("t1_q_ready", {31'd0, bus.q_ready1}, 32'd1);
        check_value("t1_q_val", bus.q_val1, 32'h1234);
        step();
        check_value("t1_rob_ready", {31'd0, bus.rob_ready}, 32'd1);
        check_value("t1_rob_rd", {27'd0, bus.rob_rd}, 32'd5);
        check_value("t1_rob_val", bus.rob_val, 32'h1234);
        check_value("t1_head", {29'd0, bus.rob_head_id}, 32'd1);
        step();
        check_value("t1_pulse_end", {31'd0, bus.rob_ready}, 32'd0);

        // fill to 8, ignore a 9th, free one slot, wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(2'd0, 5'(i + 1));
        end
        check_value("t2_full", {31'd0, bus.rob_full}, 32'd1);
        check_value("t2_tail_wrap", {29'd0, bus.rob_tail_id}, 32'd0);
        alloc(2'd0, 5'd20);
        check_value("t2_9th_tail", {29'd0, bus.rob_tail_id}, 32'd0);
        check_value("t2_9th_full", {31'd0, bus.rob_full}, 32'd1);
        alu_wb(3'd0, 32'h11, 1'b0, 32'd0);
        check_value("t2_full_hold", {31'd0, bus.rob_full}, 32'd1);
        step();
        check_value("t2_commit_rd", {27'd0, bus.rob_rd}, 32'd1);
        check_value("t2_commit_val", bus.rob_val, 32'h11);
        check_value("t2_head", {29'd0, bus.rob_head_id}, 32'd1);
        check_value("t2_not_full", {31'd0, bus.rob_full}, 32'd0);
        alloc(2'd0, 5'd9);
        check_value("t2_tail_after", {29'd0, bus.rob_tail_id}, 32'd1);
        check_value("t2_refull", {31'd0, bus.rob_full}, 32'd1);

        // out-of-order writeback, in-order retire
        do_reset();
        alloc(2'd0, 5'd10);
        alloc(2'd0, 5'd11);
        alloc(2'd0, 5'd12);
        alu_wb(3'd2, 32'h22, 1'b0, 32'd0);
        lsb_wb(3'd1, 32'h21);
        check_value("t3_wait", {31'd0, bus.rob_ready}, 32'd0);
        alu_wb(3'd0, 32'h20, 1'b0, 32'd0);
        step();
        check_value("t3_c0_rd", {27'd0, bus.rob_rd}, 32'd10);
        check_value("t3_c0_val", bus.rob_val, 32'h20);
        step();
        check_value("t3_c1_rd", {27'd0, bus.rob_rd}, 32'd11);
        check_value("t3_c1_val", bus.rob_val, 32'h21);
        step();
        check_value("t3_c2_rd", {27'd0, bus.rob_rd}, 32'd12);
        check_value("t3_c2_val", bus.rob_val, 32'h22);
        check_value("t3_c2_head", {29'd0, bus.rob_head_id}, 32'd3);
        step();
        check_value("t3_done", {31'd0, bus.rob_ready}, 32'd0);

        // mispredicted branch flush
        do_reset();
        alloc(2'd0, 5'd3);
        alloc(2'd2, 5'd0);
        alloc(2'd0, 5'd4);
        alu_wb(3'd2, 32'h44, 1'b0, 32'd0);
        alu_wb(3'd1, 32'd0, 1'b1, 32'h80);
        lsb_wb(3'd0, 32'h30);
        step();
        check_value("t4_c0_ready", {31'd0, bus.rob_ready}, 32'd1);
        check_value("t4_c0_rd", {27'd0, bus.rob_rd}, 32'd3);
        bus.dec_valid = 1'b1; bus.dec_kind = 2'd0; bus.dec_rd = 5'd7;
        step();
        bus.dec_valid = 1'b0;
        check_value("t4_flush", {31'd0, bus.rob_flush}, 32'd1);
        check_value("t4_jump_pc", bus.rob_jump_pc, 32'h80);
        check_value("t4_no_ready", {31'd0, bus.rob_ready}, 32'd0);
        check_value("t4_head", {29'd0, bus.rob_head_id}, 32'd0);
        check_value("t4_tail", {29'd0, bus.rob_tail_id}, 32'd0);
        bus.q_id1 = 3'd2;
        #1;
        check_value("t4_q_cleared", {31'd0, bus.q_ready1}, 32'd0);
        step();
        check_value("t4_flush_end", {31'd0, bus.rob_flush}, 32'd0);
        check_value("t4_id2_dead", {31'd0, bus.rob_ready}, 32'd0);
        step();
        check_value("t4_id2_dead2", {31'd0, bus.rob_ready}, 32'd0);

        // store then halt
        do_reset();
        alloc(2'd1, 5'd0);
        check_value("t5_no_store_yet", {31'd0, bus.rob_store_commit}, 32'd0);
        alloc(2'd3, 5'd0);
        check_value("t5_store", {31'd0, bus.rob_store_commit}, 32'd1);
        check_value("t5_store_head", {29'd0, bus.rob_head_id}, 32'd1);
        alloc(2'd0, 5'd6);
        check_value("t5_halt", {31'd0, bus.rob_halt}, 32'd1);
        check_value("t5_store_end", {31'd0, bus.rob_store_commit}, 32'd0);
        check_value("t5_halt_no_ready", {31'd0, bus.rob_ready}, 32'd0);
        alu_wb(3'd2, 32'h66, 1'b0, 32'd0);
        step();
        step();
        check_value("t5_halt_held", {31'd0, bus.rob_halt}, 32'd1);
        check_value("t5_no_retire", {31'd0, bus.rob_ready}, 32'd0);
        check_value("t5_head_frozen", {29'd0, bus.rob_head_id}, 32'd2);

        // same-cycle query bypass
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(2'd0, 5'(i + 1));
        end
        bus.alu_valid = 1'b1; bus.alu_id = 3'd3; bus.alu_val = 32'd7;
        bus.lsb_valid = 1'b1; bus.lsb_id = 3'd2; bus.lsb_val = 32'd9;
        bus.q_id1 = 3'd3; bus.q_id2 = 3'd2;
        #1;
        check_value("t6_byp_ready1", {31'd0, bus.q_ready1}, {31'd0, exp_byp_s});
        check_value("t6_byp_val1", bus.q_val1, exp_byp_s ? 32'd7 : 32'd0);
        check_value("t6_byp_ready2", {31'd0, bus.q_ready2}, {31'd0, exp_byp_s});
        check_value("t6_byp_val2", bus.q_val2, exp_byp_s ? 32'd9 : 32'd0);
        step();
        bus.alu_valid = 1'b0; bus.lsb_valid = 1'b0;
        #1;
        check_value("t6_q_ready1", {31'd0, bus.q_ready1}, 32'd1);
        check_value("t6_q_val1", bus.q_val1, 32'd7);
        check_value("t6_q_ready2", {31'd0, bus.q_ready2}, 32'd1);
        check_value("t6_q_val2", bus.q_val2, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
